// File: rtl/bit_reverse_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_reverse_buffer_if
// Brief    : Streaming handshake bundle for the bit-reverse frame buffer.
// Revision : 1.0
// ============================================================================
interface bit_reverse_buffer_if #(
    parameter int S_WIDTH = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [S_WIDTH-1:0] in_re;
    logic [S_WIDTH-1:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic [S_WIDTH-1:0] out_re;
    logic [S_WIDTH-1:0] out_im;
    logic               out_last;
    logic               out_first;

    modport slave (
        input  in_valid, mode, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, out_first
    );

    modport master (
        output in_valid, mode, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, out_first
    );
endinterface
`default_nettype wire

// File: rtl/bit_reverse_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bit_reverse_buffer
// Brief    : Ping-pong complex frame buffer, natural or bit-reversed read-out.
// Revision : 1.0
// ============================================================================
module bit_reverse_buffer #(
    parameter  int S_WIDTH     = 16,
    parameter  int LOG_2_WIDTH = 6,
    localparam int D_WIDTH     = 2**LOG_2_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush,
    bit_reverse_buffer_if.slave   bus
);

    localparam logic [1:0] C_ST_EMPTY    = 2'd0;
    localparam logic [1:0] C_ST_FILLING  = 2'd1;
    localparam logic [1:0] C_ST_FULL     = 2'd2;
    localparam logic [1:0] C_ST_DRAINING = 2'd3;
    localparam logic [LOG_2_WIDTH-1:0] C_LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    logic [1:0][1:0]          bank_st_q, bank_st_d;
    logic [1:0]               mode_flag_q, mode_flag_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [LOG_2_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOG_2_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [2*S_WIDTH-1:0]     mem_q [2*D_WIDTH];

    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic [LOG_2_WIDTH-1:0]   w_rd_addr;
    logic [2*S_WIDTH-1:0]     w_rd_word;

    function automatic logic [LOG_2_WIDTH-1:0] f_bitrev(input logic [LOG_2_WIDTH-1:0] a);
        logic [LOG_2_WIDTH-1:0] r;
        for (int i = 0; i < LOG_2_WIDTH; i++) begin
            r[i] = a[LOG_2_WIDTH-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q   <= {C_ST_EMPTY, C_ST_EMPTY};
            mode_flag_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            bank_st_q   <= bank_st_d;
            mode_flag_q <= mode_flag_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Write and read always target different banks, so both updates may land in one cycle.
    always_comb begin
        bank_st_d   = bank_st_q;
        mode_flag_d = mode_flag_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        if (flush) begin
            bank_st_d   = {C_ST_EMPTY, C_ST_EMPTY};
            mode_flag_d = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
        end else begin
            if (w_wr_fire) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == '0) begin
                    mode_flag_d[wr_bank_q] = bus.mode;
                end
                if (wr_cnt_q == C_LAST_IDX) begin
                    bank_st_d[wr_bank_q] = C_ST_FULL;
                    wr_bank_d            = ~wr_bank_q;
                end else begin
                    bank_st_d[wr_bank_q] = C_ST_FILLING;
                end
            end
            if (w_rd_fire) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == C_LAST_IDX) begin
                    bank_st_d[rd_bank_q] = C_ST_EMPTY;
                    rd_bank_d            = ~rd_bank_q;
                end else begin
                    bank_st_d[rd_bank_q] = C_ST_DRAINING;
                end
            end
        end
    end

    always_comb begin
        w_in_ready    = (bank_st_q[wr_bank_q] == C_ST_EMPTY) ||
                        (bank_st_q[wr_bank_q] == C_ST_FILLING);
        w_out_valid   = (bank_st_q[rd_bank_q] == C_ST_FULL) ||
                        (bank_st_q[rd_bank_q] == C_ST_DRAINING);
        w_wr_fire     = bus.in_valid && w_in_ready;
        w_rd_fire     = w_out_valid && bus.out_ready;
        w_rd_addr     = mode_flag_q[rd_bank_q] ? f_bitrev(rd_cnt_q) : rd_cnt_q;
        w_rd_word     = mem_q[{rd_bank_q, w_rd_addr}];
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_out_valid;
        bus.out_re    = w_rd_word[2*S_WIDTH-1:S_WIDTH];
        bus.out_im    = w_rd_word[S_WIDTH-1:0];
        bus.out_first = w_out_valid && (rd_cnt_q == '0);
        bus.out_last  = w_out_valid && (rd_cnt_q == C_LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire && !flush) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= {bus.in_re, bus.in_im};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_reverse_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_reverse_buffer
// Brief    : Directed frames checked against a frame-level permutation model.
// Revision : 1.0
// ============================================================================
module tb_bit_reverse_buffer;
    localparam int SW = 16;
    localparam int L  = 6;
    localparam int D  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    bit_reverse_buffer_if #(.S_WIDTH(SW)) bif ();

    bit_reverse_buffer #(.S_WIDTH(SW), .LOG_2_WIDTH(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] re;
        logic [SW-1:0] im;
        int            idx;
    } samp_t;

    samp_t exp_q[$];
    samp_t part[$];
    bit    part_mode;
    int    out_log[$];
    int    out_cyc[$];
    int    in_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    watch_low = 1'b0;
    int    low_at    = -1;

    function automatic int rev(input int i);
        int r = 0;
        for (int b = 0; b < L; b++) if (((i >> b) & 1) != 0) r += (1 << (L - 1 - b));
        return r;
    endfunction

    function automatic int lg(input int i);
        return (i < out_log.size()) ? out_log[i] : -1;
    endfunction
    function automatic int oc(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -1000;
    endfunction
    function automatic int ic(input int i);
        return (i < in_cyc.size()) ? in_cyc[i] : -1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    // Model: frames collect on input, permute once complete, then stream out in order.
    always @(negedge clk) begin
        bit    er;
        bit    ev;
        samp_t s;
        cyc++;
        if (!rst_n) begin
            chk("rst_in_ready",  bif.in_ready,  1);
            chk("rst_out_valid", bif.out_valid, 0);
            chk("rst_out_first", bif.out_first, 0);
            chk("rst_out_last",  bif.out_last,  0);
            exp_q.delete();
            part.delete();
        end else begin
            er = (part.size() > 0) || (((exp_q.size() + D - 1) / D) < 2);
            ev = (exp_q.size() > 0);
            chk("in_ready",  bif.in_ready,  er);
            chk("out_valid", bif.out_valid, ev);
            if (ev) begin
                chk("out_re",    bif.out_re,    exp_q[0].re);
                chk("out_im",    bif.out_im,    exp_q[0].im);
                chk("out_first", bif.out_first, exp_q[0].idx == 0);
                chk("out_last",  bif.out_last,  exp_q[0].idx == D - 1);
            end
            if (watch_low && !bif.in_ready) begin
                watch_low = 1'b0;
                low_at    = in_cyc.size();
            end
            if (flush) begin
                exp_q.delete();
                part.delete();
            end else begin
                if (ev && bif.out_ready) begin
                    out_log.push_back(int'(bif.out_re));
                    out_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
                if (bif.in_valid && er) begin
                    if (part.size() == 0) part_mode = bif.mode;
                    s.re  = bif.in_re;
                    s.im  = bif.in_im;
                    s.idx = 0;
                    part.push_back(s);
                    in_cyc.push_back(cyc);
                    if (part.size() == D) begin
                        for (int i = 0; i < D; i++) begin
                            s     = part[part_mode ? rev(i) : i];
                            s.idx = i;
                            exp_q.push_back(s);
                        end
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic send(input int base, input int n, input bit m, input int tog);
        bit acc;
        int t;
        for (int k = 0; k < n; k++) begin
            bif.in_valid = 1'b1;
            bif.in_re    = SW'(base + k);
            bif.in_im    = ~SW'(base + k);
            bif.mode     = (tog >= 0 && k >= tog) ? ~m : m;
            t   = 0;
            acc = 1'b0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = bif.in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            chk("send_accept", 32'(acc), 1);
            if (!acc) begin
                bif.in_valid = 1'b0;
                return;
            end
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_re     = '0;
        bif.in_im     = '0;
        bif.mode      = 1'b0;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bit-reversed frame, one-cycle latency
        clear_logs();
        bif.out_ready = 1'b1;
        send(0, D, 1'b1, -1);
        wait_drain();
        chk("t1_out0",  lg(0), 0);
        chk("t1_out1",  lg(1), 32);
        chk("t1_out2",  lg(2), 16);
        chk("t1_out3",  lg(3), 48);
        chk("t1_out4",  lg(4), 8);
        chk("t1_out63", lg(63), 63);
        chk("t1_latency", 32'(oc(0) - ic(63)), 1);

        // Natural order
        clear_logs();
        send(0, D, 1'b0, -1);
        wait_drain();
        chk("t2_out1",  lg(1), 1);
        chk("t2_out37", lg(37), 37);

        // Mode change mid-frame ignored
        clear_logs();
        send(0, D, 1'b1, 10);
        wait_drain();
        chk("t2b_out1",  lg(1), 32);
        chk("t2b_out5",  lg(5), 40);

        // Back-to-back frames, no bubbles
        clear_logs();
        for (int f = 0; f < 4; f++) send(256 + 64 * f, D, 1'b1, -1);
        wait_drain();
        chk("t3_count",   out_log.size(), 256);
        chk("t3_out_gap", 32'(oc(255) - oc(0)), 255);
        chk("t3_in_gap",  32'(ic(255) - ic(0)), 255);
        chk("t3_out0",    lg(0), 256);
        chk("t3_out65",   lg(65), 352);

        // Downstream stall: both banks fill
        clear_logs();
        bif.out_ready = 1'b0;
        watch_low = 1'b1;
        fork
            begin
                for (int f = 0; f < 4; f++) send(1000 + 64 * f, D, f[0], -1);
            end
            begin
                repeat (200) @(posedge clk);
                #1 bif.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t4_low_at", low_at, 128);
        chk("t4_count",  out_log.size(), 256);
        chk("t4_out64",  lg(64), 1064);

        // Reset mid-frame discards everything
        clear_logs();
        bif.out_ready = 1'b0;
        send(500, D, 1'b1, -1);
        send(600, 37, 1'b1, -1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_in_ready",  bif.in_ready, 1);
        chk("t5_async_out_valid", bif.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        bif.out_ready = 1'b1;
        send(100, D, 1'b1, -1);
        wait_drain();
        chk("t5_count", out_log.size(), 64);
        chk("t5_out0",  lg(0), 100);
        chk("t5_out1",  lg(1), 132);
        chk("t5_out63", lg(63), 163);

        // Flush while draining
        clear_logs();
        bif.out_ready = 1'b0;
        send(700, D, 1'b1, -1);
        clear_logs();
        bif.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_out_valid", bif.out_valid, 0);
        chk("t6_count", out_log.size(), 20);
        chk("t6_out19", lg(19), 750);
        @(posedge clk);
        #1;
        clear_logs();
        send(800, D, 1'b1, -1);
        wait_drain();
        chk("t6_out0", lg(0), 800);
        chk("t6_out2", lg(2), 816);

        chk("final_empty", exp_q.size() + part.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
